hbridge_driver: RTL and testbench



---
 rtl/hbridge_driver.sv | 165 ++++++++++++++++
 tb/tb_hbridge_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hbridge_driver.sv
// Full H-bridge gate driver: one leg PWMs with complementary dead time while the
// opposite leg's low side is held on; every polarity change or arm passes through all-off.
module hbridge_driver #(
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned REV_CYCLES  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sign,
  input  logic carrier,
  output logic hiA,
  output logic loA,
  output logic hiB,
  output logic loB,
  output logic active
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_REVERSE = 2'd1,
    ST_POS     = 2'd2,
    ST_NEG     = 2'd3
  } state_e;

  typedef struct packed {
    logic       hi;
    logic       lo;
    logic [3:0] dcnt;
  } leg_t;

  localparam logic [3:0] DEAD_MAX = 4'(DEAD_CYCLES);
  localparam logic [7:0] REV_LAST = 8'(REV_CYCLES - 1);
  localparam leg_t       LEG_STATIC_LOW = '{hi: 1'b0, lo: 1'b1, dcnt: 4'd0};
  localparam leg_t       LEG_PRESET     = '{hi: 1'b0, lo: 1'b0, dcnt: DEAD_MAX};

  state_e     state_q, state_d;
  logic       target_q, target_d;
  logic [7:0] revcnt_q, revcnt_d;
  leg_t       leg_a_q, leg_a_d;
  leg_t       leg_b_q, leg_b_d;
  logic       active_q, active_d;
  logic       enable_q, sign_q, carrier_q;

  // Dead counter: cleared while a gate conducts, otherwise counts up and saturates.
  function automatic logic [3:0] dead_next(input leg_t cur);
    logic [3:0] nxt;
    if (cur.hi || cur.lo) begin
      nxt = 4'd0;
    end else if (cur.dcnt >= DEAD_MAX) begin
      nxt = DEAD_MAX;
    end else begin
      nxt = cur.dcnt + 4'd1;
    end
    return nxt;
  endfunction

  // A mismatching gate drops at once; the wanted gate rises only after a full dead interval.
  function automatic leg_t leg_step(input leg_t cur, input logic want_hi);
    leg_t nxt;
    nxt.dcnt = dead_next(cur);
    if (!cur.hi && !cur.lo && (nxt.dcnt == DEAD_MAX)) begin
      nxt.hi = want_hi;
      nxt.lo = ~want_hi;
    end else begin
      nxt.hi = cur.hi & want_hi;
      nxt.lo = cur.lo & ~want_hi;
    end
    return nxt;
  endfunction

  // Next-state and gate decode; every path defaults to all gates off.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    revcnt_d = revcnt_q;
    leg_a_d  = '{hi: 1'b0, lo: 1'b0, dcnt: dead_next(leg_a_q)};
    leg_b_d  = '{hi: 1'b0, lo: 1'b0, dcnt: dead_next(leg_b_q)};
    if (!enable_q) begin
      state_d  = ST_OFF;
      revcnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_REVERSE;
          target_d = sign_q;
          revcnt_d = 8'd0;
        end
        ST_REVERSE: begin
          target_d = sign_q;
          revcnt_d = revcnt_q + 8'd1;
          if (revcnt_q == REV_LAST) begin
            revcnt_d = 8'd0;
            if (target_q) begin
              state_d = ST_NEG;
              leg_a_d = LEG_STATIC_LOW;
              leg_b_d = leg_step(LEG_PRESET, carrier_q);
            end else begin
              state_d = ST_POS;
              leg_a_d = leg_step(LEG_PRESET, carrier_q);
              leg_b_d = LEG_STATIC_LOW;
            end
          end else begin
            state_d = ST_REVERSE;
          end
        end
        ST_POS: begin
          if (sign_q) begin
            state_d  = ST_REVERSE;
            revcnt_d = 8'd0;
          end else begin
            leg_a_d = leg_step(leg_a_q, carrier_q);
            leg_b_d = LEG_STATIC_LOW;
          end
        end
        ST_NEG: begin
          if (!sign_q) begin
            state_d  = ST_REVERSE;
            revcnt_d = 8'd0;
          end else begin
            leg_a_d = LEG_STATIC_LOW;
            leg_b_d = leg_step(leg_b_q, carrier_q);
          end
        end
        default: begin
          state_d  = ST_OFF;
          revcnt_d = 8'd0;
        end
      endcase
    end
    active_d = (state_d == ST_POS) || (state_d == ST_NEG);
  end

  // Input capture and all state/output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q  <= 1'b0;
      sign_q    <= 1'b0;
      carrier_q <= 1'b0;
      state_q   <= ST_OFF;
      target_q  <= 1'b0;
      revcnt_q  <= 8'd0;
      leg_a_q   <= '0;
      leg_b_q   <= '0;
      active_q  <= 1'b0;
    end else begin
      enable_q  <= enable;
      sign_q    <= sign;
      carrier_q <= carrier;
      state_q   <= state_d;
      target_q  <= target_d;
      revcnt_q  <= revcnt_d;
      leg_a_q   <= leg_a_d;
      leg_b_q   <= leg_b_d;
      active_q  <= active_d;
    end
  end

  assign hiA    = leg_a_q.hi;
  assign loA    = leg_a_q.lo;
  assign hiB    = leg_b_q.hi;
  assign loB    = leg_b_q.lo;
  assign active = active_q;

endmodule

// File: tb/tb_hbridge_driver.sv
// Scoreboard bench for hbridge_driver: directed phases push per-edge expected
// gate vectors {hiA,loA,hiB,loB,active}; a negedge monitor pops and compares.
module tb_hbridge_driver;

  localparam int DEAD = 4;
  localparam int REV  = 16;

  localparam logic [4:0] V_OFF  = 5'b00000;
  localparam logic [4:0] P_LO   = 5'b01011;
  localparam logic [4:0] P_HI   = 5'b10011;
  localparam logic [4:0] P_DT   = 5'b00011;
  localparam logic [4:0] N_LO   = 5'b01011;
  localparam logic [4:0] N_HI   = 5'b01101;
  localparam logic [4:0] N_DT   = 5'b01001;

  logic clk = 1'b0;
  logic reset, enable, sign, carrier;
  logic hiA, loA, hiB, loB, active;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  int         q_e[$];
  logic [4:0] q_v[$];
  string      q_n[$];

  logic [4:0] got;
  logic       pa_hi = 1'b0, pa_lo = 1'b0, pb_hi = 1'b0, pb_lo = 1'b0;
  int         off_a = 0, off_b = 0;

  hbridge_driver #(.DEAD_CYCLES(DEAD), .REV_CYCLES(REV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sign(sign), .carrier(carrier),
    .hiA(hiA), .loA(loA), .hiB(hiB), .loB(loB), .active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic exp_rng(input int a, input int z, input logic [4:0] v, input string nm);
    for (int e = a; e <= z; e++) begin
      q_e.push_back(e);
      q_v.push_back(v);
      q_n.push_back(nm);
    end
  endtask

  task automatic at_neg(input int e);
    do @(negedge clk); while (edge_n < e);
  endtask

  // Monitor: scoreboard compare, safety invariants and dead-time measurement.
  always @(negedge clk) begin
    got = {hiA, loA, hiB, loB, active};
    while (q_e.size() > 0 && q_e[0] <= edge_n) begin
      checks = checks + 1;
      if (q_e[0] < edge_n) begin
        errors = errors + 1;
        $display("FAIL %s edge=%0d not sampled (now %0d)", q_n[0], q_e[0], edge_n);
      end else if (got !== q_v[0]) begin
        errors = errors + 1;
        $display("FAIL %s edge=%0d got=%b exp=%b", q_n[0], edge_n, got, q_v[0]);
      end
      void'(q_e.pop_front());
      void'(q_v.pop_front());
      void'(q_n.pop_front());
    end
    checks = checks + 1;
    if ((hiA & loA) || (hiB & loB) || (hiA & hiB) || (!active && (hiA || hiB))) begin
      errors = errors + 1;
      $display("FAIL invariant edge=%0d got=%b exp=no shoot-through", edge_n, got);
    end
    if ((hiA && !pa_hi) || (loA && !pa_lo)) begin
      checks = checks + 1;
      if (pa_hi || pa_lo || off_a < DEAD) begin
        errors = errors + 1;
        $display("FAIL deadtime_A edge=%0d got=%0d exp>=%0d", edge_n, off_a, DEAD);
      end
    end
    if ((hiB && !pb_hi) || (loB && !pb_lo)) begin
      checks = checks + 1;
      if (pb_hi || pb_lo || off_b < DEAD) begin
        errors = errors + 1;
        $display("FAIL deadtime_B edge=%0d got=%0d exp>=%0d", edge_n, off_b, DEAD);
      end
    end
    off_a = (hiA || loA) ? 0 : off_a + 1;
    off_b = (hiB || loB) ? 0 : off_b + 1;
    pa_hi = hiA; pa_lo = loA; pb_hi = hiB; pb_lo = loB;
  end

  initial begin
    int b;
    reset = 1'b1; enable = 1'b0; sign = 1'b0; carrier = 1'b0;
    @(negedge clk); b = edge_n;
    exp_rng(b + 1, b + 2, V_OFF, "reset");
    at_neg(b + 2); b = edge_n;

    // Arm positive: OFF, full REVERSE, then both low sides on.
    reset = 1'b0; enable = 1'b1;
    exp_rng(b + 1, b + 17, V_OFF, "startup_off");
    exp_rng(b + 18, b + 20, P_LO, "startup_pos");
    at_neg(b + 20); b = edge_n;

    carrier = 1'b1;
    exp_rng(b + 1, b + 1, P_LO, "pos_rise_hold");
    exp_rng(b + 2, b + 5, P_DT, "pos_rise_dead");
    exp_rng(b + 6, b + 8, P_HI, "pos_rise_hi");
    at_neg(b + 8); b = edge_n;

    carrier = 1'b0;
    exp_rng(b + 1, b + 1, P_HI, "pos_fall_hold");
    exp_rng(b + 2, b + 5, P_DT, "pos_fall_dead");
    exp_rng(b + 6, b + 8, P_LO, "pos_fall_lo");
    at_neg(b + 8); b = edge_n;

    // Two-cycle carrier pulse is absorbed by the dead time.
    carrier = 1'b1;
    exp_rng(b + 1, b + 1, P_LO, "pulse_hold");
    exp_rng(b + 2, b + 5, P_DT, "pulse_dead");
    exp_rng(b + 6, b + 8, P_LO, "pulse_lo");
    at_neg(b + 2);
    carrier = 1'b0;
    at_neg(b + 8); b = edge_n;

    carrier = 1'b1;
    exp_rng(b + 1, b + 1, P_LO, "pos_rise2_hold");
    exp_rng(b + 2, b + 5, P_DT, "pos_rise2_dead");
    exp_rng(b + 6, b + 8, P_HI, "pos_rise2_hi");
    at_neg(b + 8); b = edge_n;

    // Reversal to negative while hiA conducts.
    sign = 1'b1;
    exp_rng(b + 1, b + 1, P_HI, "rev_hold");
    exp_rng(b + 2, b + 17, V_OFF, "rev_off");
    exp_rng(b + 18, b + 20, N_HI, "neg_entry");
    at_neg(b + 20); b = edge_n;

    carrier = 1'b0;
    exp_rng(b + 1, b + 1, N_HI, "neg_fall_hold");
    exp_rng(b + 2, b + 5, N_DT, "neg_fall_dead");
    exp_rng(b + 6, b + 8, N_LO, "neg_fall_lo");
    at_neg(b + 8); b = edge_n;

    carrier = 1'b1;
    exp_rng(b + 1, b + 1, N_LO, "neg_rise_hold");
    exp_rng(b + 2, b + 5, N_DT, "neg_rise_dead");
    exp_rng(b + 6, b + 8, N_HI, "neg_rise_hi");
    at_neg(b + 8); b = edge_n;

    enable = 1'b0;
    exp_rng(b + 1, b + 1, N_HI, "disable_hold");
    exp_rng(b + 2, b + 5, V_OFF, "disable_off");
    at_neg(b + 5); b = edge_n;

    enable = 1'b1;
    exp_rng(b + 1, b + 17, V_OFF, "reenable_off");
    exp_rng(b + 18, b + 20, N_HI, "reenable_neg");
    at_neg(b + 20); b = edge_n;

    // Reset while hiB conducts, then re-arm from scratch.
    reset = 1'b1;
    exp_rng(b + 1, b + 2, V_OFF, "reset_mid");
    at_neg(b + 2); b = edge_n;
    reset = 1'b0;
    exp_rng(b + 1, b + 17, V_OFF, "rearm_off");
    exp_rng(b + 18, b + 20, N_HI, "rearm_neg");
    at_neg(b + 20); b = edge_n;

    // Sign bounces back inside REVERSE: interval is not restarted.
    sign = 1'b0;
    exp_rng(b + 1, b + 1, N_HI, "glitch_hold");
    exp_rng(b + 2, b + 17, V_OFF, "glitch_off");
    exp_rng(b + 18, b + 20, N_HI, "glitch_neg");
    at_neg(b + 5);
    sign = 1'b1;
    at_neg(b + 20); b = edge_n;

    // Random traffic: only invariants and dead time are judged here.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) sign = ~sign;
      if ($urandom_range(0, 2) == 0) carrier = ~carrier;
    end

    @(negedge clk); b = edge_n;
    reset = 1'b1;
    exp_rng(b + 1, b + 2, V_OFF, "final_reset");
    at_neg(b + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
